// File: rtl/osd_overlay_if.sv
// rtl/osd_overlay_if.sv - parallel video stream bundle (hs/vs/de/data)
interface osd_overlay_if #(
   parameter int DATA_W = 24
);
   logic              hs;
   logic              vs;
   logic              de;
   logic [DATA_W-1:0] data;

   modport master (output hs, vs, de, data);
   modport slave  (input  hs, vs, de, data);
endinterface

// File: rtl/osd_overlay.sv
// rtl/osd_overlay.sv - inline 1bpp bitmap overlay with ROM fetch and per-frame shadow config
// Optional 2x scaling is built when OSD_SCALE2X_EN is defined.
module osd_overlay #(
   parameter int DATA_W  = 24,
   parameter int COORD_W = 12,
   parameter int OSD_W   = 344,
   parameter int OSD_H   = 48,
   parameter int ROM_DW  = 8,
   parameter int ROM_AW  = 13,
   parameter int VS_POL  = 1
) (
   input  logic               pclk,
   input  logic               rst_n,
   osd_overlay_if.slave       vin,
   osd_overlay_if.master      vout,
   input  logic               osd_en,
   input  logic [COORD_W-1:0] osd_x,
   input  logic [COORD_W-1:0] osd_y,
   input  logic [DATA_W-1:0]  fg_color,
   input  logic [DATA_W-1:0]  bg_color,
   input  logic               bg_en,
`ifdef OSD_SCALE2X_EN
   input  logic               scale2x,
`endif
   output logic [ROM_AW-1:0]  rom_addr,
   input  logic [ROM_DW-1:0]  rom_q
);

   localparam int CW1  = COORD_W + 1;
   localparam int BS_W = $clog2(ROM_DW);
   localparam int P_W  = ROM_AW + BS_W;
   localparam logic [CW1-1:0] W_1X     = CW1'(OSD_W);
   localparam logic [CW1-1:0] H_1X     = CW1'(OSD_H);
   localparam logic [P_W-1:0] ROW_STEP = P_W'(OSD_W);
`ifdef OSD_SCALE2X_EN
   localparam logic [CW1-1:0] W_2X     = CW1'(2 * OSD_W);
   localparam logic [CW1-1:0] H_2X     = CW1'(2 * OSD_H);
`endif

   logic               vs_prev, de_prev;
   logic [COORD_W-1:0] x_cnt, y_cnt;
   logic               sh_en, sh_bg_en;
   logic [COORD_W-1:0] sh_x, sh_y;
   logic [DATA_W-1:0]  sh_fg, sh_bg;
   logic [P_W-1:0]     row_base;
`ifdef OSD_SCALE2X_EN
   logic               sh_s2;
`endif

   logic               vs_act, vs_edge, de_fall;
   logic [CW1-1:0]     x_e, y_e, ox_e, oy_e, span_w, span_h, dx, col;
   logic               in_x, in_y, row_last, hit;
   logic [P_W-1:0]     pix;

   logic               hit_q, hs_q, vs_q, de_q;
   logic [BS_W-1:0]    bit_q;
   logic [DATA_W-1:0]  alt_q, fg_q;

   always_comb begin
      vs_act  = (vin.vs == (VS_POL != 0));
      vs_edge = vs_act & ~vs_prev;
      de_fall = de_prev & ~vin.de;
      x_e     = {1'b0, x_cnt};
      y_e     = {1'b0, y_cnt};
      ox_e    = {1'b0, sh_x};
      oy_e    = {1'b0, sh_y};
      dx      = x_e - ox_e;
`ifdef OSD_SCALE2X_EN
      span_w   = sh_s2 ? W_2X : W_1X;
      span_h   = sh_s2 ? H_2X : H_1X;
      col      = sh_s2 ? (dx >> 1) : dx;
      // odd offset from osd_y is the second screen line of a bitmap row
      row_last = sh_s2 ? (y_cnt[0] ^ sh_y[0]) : 1'b1;
`else
      span_w   = W_1X;
      span_h   = H_1X;
      col      = dx;
      row_last = 1'b1;
`endif
      in_x = (x_e >= ox_e) && (x_e < ox_e + span_w);
      in_y = (y_e >= oy_e) && (y_e < oy_e + span_h);
      hit  = vin.de & sh_en & in_x & in_y;
      pix  = row_base + P_W'(col);
   end

   // Counters, frame shadow and row base
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_prev  <= 1'b0;
         de_prev  <= 1'b0;
         x_cnt    <= '0;
         y_cnt    <= '0;
         sh_en    <= 1'b0;
         sh_bg_en <= 1'b0;
         sh_x     <= '0;
         sh_y     <= '0;
         sh_fg    <= '0;
         sh_bg    <= '0;
         row_base <= '0;
`ifdef OSD_SCALE2X_EN
         sh_s2    <= 1'b0;
`endif
      end else begin
         vs_prev <= vs_act;
         de_prev <= vin.de;
         x_cnt   <= vin.de ? x_cnt + COORD_W'(1) : '0;
         if (vs_edge)
            y_cnt <= '0;
         else if (de_fall)
            y_cnt <= y_cnt + COORD_W'(1);
         if (vs_edge) begin
            sh_en    <= osd_en;
            sh_bg_en <= bg_en;
            sh_x     <= osd_x;
            sh_y     <= osd_y;
            sh_fg    <= fg_color;
            sh_bg    <= bg_color;
            row_base <= '0;
`ifdef OSD_SCALE2X_EN
            sh_s2    <= scale2x;
`endif
         end else if (de_fall && in_y && row_last) begin
            row_base <= row_base + ROW_STEP;
         end
      end
   end

   // Stage 1: ROM address and pre-selected colours travel with the pixel
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
         bit_q    <= '0;
         hit_q    <= 1'b0;
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         de_q     <= 1'b0;
         alt_q    <= '0;
         fg_q     <= '0;
      end else begin
         hit_q <= hit;
         if (hit) begin
            rom_addr <= pix[P_W-1:BS_W];
            bit_q    <= pix[BS_W-1:0];
         end
         hs_q  <= vin.hs;
         vs_q  <= vin.vs;
         de_q  <= vin.de;
         alt_q <= (hit && sh_bg_en) ? sh_bg : vin.data;
         fg_q  <= sh_fg;
      end
   end

   // Stage 2: blend with the ROM word returned for the stage-1 address
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vout.hs   <= 1'b0;
         vout.vs   <= 1'b0;
         vout.de   <= 1'b0;
         vout.data <= '0;
      end else begin
         vout.hs   <= hs_q;
         vout.vs   <= vs_q;
         vout.de   <= de_q;
         vout.data <= (hit_q && rom_q[bit_q]) ? fg_q : alt_q;
      end
   end

endmodule

// File: tb/tb_osd_overlay.sv
// tb/tb_osd_overlay.sv - randomized scoreboard bench for osd_overlay
module tb_osd_overlay;
   localparam int DATA_W  = 24;
   localparam int COORD_W = 12;
   localparam int OSD_W   = 344;
   localparam int OSD_H   = 48;
   localparam int ROM_DW  = 8;
   localparam int ROM_AW  = 13;
   localparam logic VS_ON = 1'b1;

   logic               pclk = 1'b0;
   logic               rst_n = 1'b0;
   logic               osd_en = 1'b0, bg_en = 1'b0;
   logic [COORD_W-1:0] osd_x = '0, osd_y = '0;
   logic [DATA_W-1:0]  fg_color = '0, bg_color = '0;
`ifdef OSD_SCALE2X_EN
   logic               scale2x = 1'b0;
`endif
   logic [ROM_AW-1:0]  rom_addr;
   logic [ROM_DW-1:0]  rom_q;
   logic [ROM_DW-1:0]  rom [0:(1<<ROM_AW)-1];

   osd_overlay_if #(.DATA_W(DATA_W)) vin ();
   osd_overlay_if #(.DATA_W(DATA_W)) vout ();

   osd_overlay #(.DATA_W(DATA_W), .COORD_W(COORD_W), .OSD_W(OSD_W), .OSD_H(OSD_H),
                 .ROM_DW(ROM_DW), .ROM_AW(ROM_AW), .VS_POL(1)) dut (
      .pclk(pclk), .rst_n(rst_n), .vin(vin), .vout(vout),
      .osd_en(osd_en), .osd_x(osd_x), .osd_y(osd_y),
      .fg_color(fg_color), .bg_color(bg_color), .bg_en(bg_en),
`ifdef OSD_SCALE2X_EN
      .scale2x(scale2x),
`endif
      .rom_addr(rom_addr), .rom_q(rom_q));

   assign rom_q = rom[rom_addr];
   always #5 pclk = ~pclk;

   typedef struct { int due; logic hs; logic vs; logic de; logic [DATA_W-1:0] data; } out_t;
   typedef struct { int due; logic [ROM_AW-1:0] addr; } addr_t;
   out_t  oq[$];
   addr_t aq[$];
   int cyc = 0;
   int checks = 0, errs = 0;

   // reference model state: the shadowed frame configuration
   logic m_en, m_bgen, m_vsp, m_s2;
   int   m_ox, m_oy;
   logic [DATA_W-1:0] m_fg, m_bg;
   logic [ROM_AW-1:0] m_addr;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic model_reset();
      m_en = 0; m_bgen = 0; m_vsp = 0; m_s2 = 0;
      m_ox = 0; m_oy = 0; m_fg = '0; m_bg = '0; m_addr = '0;
   endtask

   task automatic drive(input logic hs, input logic vs, input logic de,
                        input logic [DATA_W-1:0] d, input int x, input int y);
      int s, p;
      logic hit, bv;
      logic [DATA_W-1:0] ed;
      @(posedge pclk); #1;
      vin.hs = hs; vin.vs = vs; vin.de = de; vin.data = d;
      s   = m_s2 ? 2 : 1;
      hit = m_en && de && x >= m_ox && x < m_ox + s*OSD_W && y >= m_oy && y < m_oy + s*OSD_H;
      ed  = d;
      if (hit) begin
         p      = ((y - m_oy) / s) * OSD_W + (x - m_ox) / s;
         m_addr = ROM_AW'(p / ROM_DW);
         bv     = rom[p / ROM_DW][p % ROM_DW];
         ed     = bv ? m_fg : (m_bgen ? m_bg : d);
      end
      aq.push_back('{due: cyc + 1, addr: m_addr});
      oq.push_back('{due: cyc + 2, hs: hs, vs: vs, de: de, data: ed});
      if (vs == VS_ON && !m_vsp) begin
         m_en = osd_en; m_ox = int'(osd_x); m_oy = int'(osd_y);
         m_fg = fg_color; m_bg = bg_color; m_bgen = bg_en;
`ifdef OSD_SCALE2X_EN
         m_s2 = scale2x;
`else
         m_s2 = 1'b0;
`endif
      end
      m_vsp = (vs == VS_ON);
   endtask

   task automatic do_reset();
      @(posedge pclk); #1;
      rst_n = 1'b0;
      vin.hs = 1'b0; vin.vs = ~VS_ON; vin.de = 1'b0; vin.data = '0;
      oq.delete(); aq.delete();
      model_reset();
      repeat (2) begin
         @(negedge pclk);
         checks++;
         if ({vout.hs, vout.vs, vout.de, vout.data, rom_addr} !== '0) begin
            errs++;
            $display("FAIL reset_state got hs=%b vs=%b de=%b data=%h addr=%0d exp all zero",
                     vout.hs, vout.vs, vout.de, vout.data, rom_addr);
         end
      end
      @(posedge pclk); #1;
      rst_n = 1'b1;
   endtask

   task automatic frame(input int w, input int h, input bit const_data,
                        input int chg_line, input int rst_line);
      for (int i = 0; i < 2; i++) drive(1'b0, VS_ON, 1'b0, '0, 0, 0);
      for (int i = 0; i < 3; i++) drive(1'b0, ~VS_ON, 1'b0, '0, 0, 0);
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++)
            drive(1'b0, ~VS_ON, 1'b1, const_data ? 24'h00FF00 : DATA_W'($urandom), x, y);
         if (y == chg_line) osd_x = 12'd50;
         for (int b = 0; b < 4; b++)
            drive(b == 1 || b == 2, ~VS_ON, 1'b0, DATA_W'($urandom), 0, 0);
         if (y == rst_line) do_reset();
      end
   endtask

   // monitor: compares DUT outputs against queued expectations when they fall due
   initial begin
      out_t  o;
      addr_t a;
      forever begin
         @(negedge pclk);
         if (rst_n) begin
            while (aq.size() > 0 && aq[0].due <= cyc) begin
               a = aq.pop_front();
               checks++;
               if (a.due != cyc || rom_addr !== a.addr) begin
                  errs++;
                  $display("FAIL rom_addr cyc=%0d due=%0d got=%0d exp=%0d", cyc, a.due, rom_addr, a.addr);
               end
            end
            while (oq.size() > 0 && oq[0].due <= cyc) begin
               o = oq.pop_front();
               checks++;
               if (o.due != cyc || vout.hs !== o.hs || vout.vs !== o.vs ||
                   vout.de !== o.de || vout.data !== o.data) begin
                  errs++;
                  $display("FAIL pixel cyc=%0d got hs=%b vs=%b de=%b data=%h exp hs=%b vs=%b de=%b data=%h",
                           cyc, vout.hs, vout.vs, vout.de, vout.data, o.hs, o.vs, o.de, o.data);
               end
            end
         end
      end
   end

   initial begin
      vin.hs = 1'b0; vin.vs = ~VS_ON; vin.de = 1'b0; vin.data = '0;
      for (int i = 0; i < (1<<ROM_AW); i++) rom[i] = ROM_DW'($urandom);
      model_reset();
      do_reset();

      // basic hit: word 0 = 0x01, transparent zeros, constant green input
      rom[0] = 8'h01;
      osd_en = 1'b1; osd_x = 12'd10; osd_y = 12'd5; bg_en = 1'b0;
      fg_color = 24'hFF0000; bg_color = DATA_W'($urandom);
      frame(360, 56, 1'b1, -1, -1);

      // opaque background over an all-zero bitmap, with margins outside
      for (int i = 0; i < (1<<ROM_AW); i++) rom[i] = '0;
      bg_en = 1'b1; bg_color = 24'h0000FF; osd_x = 12'd3; osd_y = 12'd2;
      frame(350, 52, 1'b0, -1, -1);

      // right-edge clipping; osd_x changed mid-frame applies next frame
      for (int i = 0; i < (1<<ROM_AW); i++) rom[i] = ROM_DW'($urandom);
      osd_x = 12'd400; osd_y = 12'd2; bg_en = 1'($urandom);
      fg_color = DATA_W'($urandom); bg_color = DATA_W'($urandom);
      frame(480, 12, 1'b0, 5, -1);

      // new position, then reset mid-frame: pass-through until next vs
      frame(480, 10, 1'b0, -1, 4);

      // overlay disabled in the latched config
      osd_en = 1'b0;
      frame(400, 8, 1'b0, -1, -1);

      // random placement and colours
      for (int k = 0; k < 2; k++) begin
         osd_en = 1'b1; osd_x = COORD_W'($urandom_range(0, 150));
         osd_y = COORD_W'($urandom_range(0, 15)); bg_en = 1'($urandom);
         fg_color = DATA_W'($urandom); bg_color = DATA_W'($urandom);
         frame(200, 20, 1'b0, -1, -1);
      end

`ifdef OSD_SCALE2X_EN
      scale2x = 1'b1; osd_x = 12'd5; osd_y = 12'd1; bg_en = 1'b0;
      frame(700, 6, 1'b0, -1, -1);
      osd_x = 12'd0; osd_y = 12'd0; bg_en = 1'b1;
      frame(40, 100, 1'b0, -1, -1);
      scale2x = 1'b0;
      frame(40, 10, 1'b0, -1, -1);
`endif

      repeat (4) drive(1'b0, ~VS_ON, 1'b0, '0, 0, 0);
      repeat (3) @(negedge pclk);
      if (oq.size() != 0 || aq.size() != 0) begin
         checks++; errs++;
         $display("FAIL drain got %0d pending exp 0", oq.size() + aq.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
